// File: rtl/wb_seg_mem.sv
// MEM->WB segment register with embedded synchronous data RAM, store alignment,
// load extraction/extension and stall-safe load hold. Optional second RAM port: WB_SEG_MEM_DEBUG_PORT_EN.
module wb_seg_mem #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned RD_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [XLEN-1:0]   addr_m,
  input  logic [XLEN-1:0]   wd_m,
  input  logic [2:0]        mem_op_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [XLEN-1:0]   result_m,
  input  logic [RD_W-1:0]   rd_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
`ifdef WB_SEG_MEM_DEBUG_PORT_EN
  input  logic [XLEN-1:0]   dbg_addr,
  input  logic [XLEN-1:0]   dbg_wd,
  input  logic [XLEN/8-1:0] dbg_we,
  output logic [XLEN-1:0]   dbg_rd,
`endif
  output logic [XLEN-1:0]   result_w,
  output logic [RD_W-1:0]   rd_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [XLEN-1:0]   load_data_w,
  output logic              misalign_w
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [OFF_W-1:0]      off_m;
  logic [DEPTH_LOG2-1:0] idx_m;
  logic [3:0]            off_ext;
  logic [3:0]            size_m;
  logic                  legal_m;
  logic                  mis_m;
  logic                  we;
  logic [NB-1:0]         be;
  logic [XLEN-1:0]       wdata;
  logic                  unused_addr;

  assign off_m       = addr_m[OFF_W-1:0];
  assign idx_m       = addr_m[DEPTH_LOG2+OFF_W-1:OFF_W];
  assign off_ext     = 4'(off_m);
  assign size_m      = 4'd1 << mem_op_m[1:0];
  assign unused_addr = ^addr_m[XLEN-1:DEPTH_LOG2+OFF_W];

  always_comb begin
    legal_m = 1'b1;
    case (mem_op_m)
      3'b011, 3'b110: legal_m = (XLEN == 64);
      3'b111:         legal_m = 1'b0;
      default:        legal_m = 1'b1;
    endcase
  end

  // Illegal ops are neither written nor flagged.
  assign mis_m = (mem_read_m | mem_write_m) & legal_m &
                 ((off_ext & (size_m - 4'd1)) != 4'd0);
  assign we    = mem_write_m & en & ~clear & ~rst & legal_m & ~mis_m;
  assign wdata = wd_m << {off_m, 3'b000};

  always_comb begin
    be = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be[i] = (4'(i) >= off_ext) && (4'(i) < off_ext + size_m);
    end
  end

  // Data RAM: read-first, never reset.
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_q;

`ifdef WB_SEG_MEM_DEBUG_PORT_EN
  logic [DEPTH_LOG2-1:0] dbg_idx;
  logic                  unused_dbg_addr;
  assign dbg_idx         = dbg_addr[DEPTH_LOG2+OFF_W-1:OFF_W];
  assign unused_dbg_addr = ^{dbg_addr[XLEN-1:DEPTH_LOG2+OFF_W], dbg_addr[OFF_W-1:0]};
`endif

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[idx_m][8*i +: 8] <= wdata[8*i +: 8];
      end
`ifdef WB_SEG_MEM_DEBUG_PORT_EN
      if (dbg_we[i]) begin
        mem[dbg_idx][8*i +: 8] <= dbg_wd[8*i +: 8];
      end
`endif
    end
    rdata_q <= mem[idx_m];
`ifdef WB_SEG_MEM_DEBUG_PORT_EN
    dbg_rd <= mem[dbg_idx];
`endif
  end

  // Stage registers.
  logic [OFF_W-1:0] off_w;
  logic [2:0]       op_w;
  logic             ld_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_w     <= '0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      misalign_w   <= 1'b0;
      off_w        <= '0;
      op_w         <= '0;
      ld_valid_q   <= 1'b0;
    end else if (en) begin
      if (clear) begin
        result_w     <= '0;
        rd_w         <= '0;
        reg_write_w  <= 1'b0;
        mem_to_reg_w <= 1'b0;
        misalign_w   <= 1'b0;
        off_w        <= '0;
        op_w         <= '0;
        ld_valid_q   <= 1'b0;
      end else begin
        result_w     <= result_m;
        rd_w         <= rd_m;
        reg_write_w  <= reg_write_m & ~mis_m;
        mem_to_reg_w <= mem_to_reg_m;
        misalign_w   <= mis_m;
        off_w        <= off_m;
        op_w         <= mem_op_m;
        ld_valid_q   <= mem_read_m;
      end
    end
  end

  // Load extraction and extension.
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    shifted = rdata_q >> {off_w, 3'b000};
    ext     = '0;
    case (op_w)
      3'b000: ext = XLEN'($signed(shifted[7:0]));
      3'b001: ext = XLEN'($signed(shifted[15:0]));
      3'b010: ext = XLEN'($signed(shifted[31:0]));
      3'b011: ext = (XLEN == 64) ? shifted : '0;
      3'b100: ext = XLEN'(shifted[7:0]);
      3'b101: ext = XLEN'(shifted[15:0]);
      3'b110: ext = (XLEN == 64) ? XLEN'(shifted[31:0]) : '0;
      default: ext = '0;
    endcase
  end

  assign load_ext = ld_valid_q ? ext : '0;

  // The RAM keeps reading during a stall, so the first WB-cycle value is parked here.
  logic            stall_q;
  logic [XLEN-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      stall_q <= ~en;
      if (!stall_q) begin
        hold_q <= load_ext;
      end
    end
  end

  assign load_data_w = stall_q ? hold_q : load_ext;

endmodule

// File: tb/tb_wb_seg_mem.sv
// Self-checking bench for wb_seg_mem: directed vector table, hand-written stall/clear/reset
// and XLEN=64 sequences, and randomized traffic against a byte-array reference model.
module tb_wb_seg_mem;

  logic        clk = 1'b0;
  logic        rst, en, clear;
  logic [63:0] addr, wd, result;
  logic [2:0]  op;
  logic        mrd, mwr, rw, m2r;
  logic [4:0]  rd;

  logic [31:0] r32, ld32;
  logic [4:0]  rd32;
  logic        rw32, m2r32, mis32;
  logic [63:0] r64, ld64;
  logic [4:0]  rd64;
  logic        rw64, m2r64, mis64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef WB_SEG_MEM_DEBUG_PORT_EN
  logic [31:0] dbg_rd32;
  logic [63:0] dbg_rd64;
`endif

  wb_seg_mem #(.XLEN(32), .DEPTH_LOG2(12), .RD_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .addr_m(addr[31:0]), .wd_m(wd[31:0]), .mem_op_m(op),
    .mem_read_m(mrd), .mem_write_m(mwr), .result_m(result[31:0]), .rd_m(rd),
    .reg_write_m(rw), .mem_to_reg_m(m2r),
`ifdef WB_SEG_MEM_DEBUG_PORT_EN
    .dbg_addr(32'h0), .dbg_wd(32'h0), .dbg_we(4'h0), .dbg_rd(dbg_rd32),
`endif
    .result_w(r32), .rd_w(rd32), .reg_write_w(rw32), .mem_to_reg_w(m2r32),
    .load_data_w(ld32), .misalign_w(mis32)
  );

  wb_seg_mem #(.XLEN(64), .DEPTH_LOG2(10), .RD_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .addr_m(addr), .wd_m(wd), .mem_op_m(op),
    .mem_read_m(mrd), .mem_write_m(mwr), .result_m(result), .rd_m(rd),
    .reg_write_m(rw), .mem_to_reg_m(m2r),
`ifdef WB_SEG_MEM_DEBUG_PORT_EN
    .dbg_addr(64'h0), .dbg_wd(64'h0), .dbg_we(8'h0), .dbg_rd(dbg_rd64),
`endif
    .result_w(r64), .rd_w(rd64), .reg_write_w(rw64), .mem_to_reg_w(m2r64),
    .load_data_w(ld64), .misalign_w(mis64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [63:0] a, input logic [63:0] d,
                       input logic r, input logic w, input logic regw);
    op = o; addr = a; wd = d; mrd = r; mwr = w; rw = regw; m2r = r;
  endtask

  task automatic check_zero32(input string tag);
    check({tag, ".result"}, 64'(r32), 64'h0);
    check({tag, ".rd"}, 64'(rd32), 64'h0);
    check({tag, ".reg_write"}, 64'(rw32), 64'h0);
    check({tag, ".mem_to_reg"}, 64'(m2r32), 64'h0);
    check({tag, ".misalign"}, 64'(mis32), 64'h0);
    check({tag, ".load_data"}, 64'(ld32), 64'h0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        chk_ld;
    logic [31:0] exp_ld;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                              input logic r, input logic w, input logic regw, input logic c,
                              input logic [31:0] e, input logic m, input logic erw);
    vec_t v;
    v.op = o; v.addr = a; v.wd = d; v.rd = r; v.wr = w; v.rw = regw;
    v.chk_ld = c; v.exp_ld = e; v.exp_mis = m; v.exp_rw = erw;
    return v;
  endfunction

  // Reference memory for the random phase: bytes 0x100..0x13F.
  logic [7:0] mbytes [64];

  function automatic logic [31:0] model_load(input logic [2:0] o, input int unsigned a);
    logic [31:0] v;
    int unsigned sz;
    v = 32'h0;
    sz = 1 << o[1:0];
    for (int unsigned i = 0; i < sz; i++) v[8*i +: 8] = mbytes[a - 32'h100 + i];
    case (o)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'h0, v[7:0]};
      3'd5:    return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  vec_t vecs[17];

  initial begin
    logic [2:0]  lops[8];
    logic [2:0]  sops[8];
    logic [31:0] exp_ld;
    logic        exp_chk, exp_mis, exp_rw;

    vecs[0]  = mk(3'd2, 32'h10, 32'h80FF7F01, 0, 1, 0, 0, 32'h0,        0, 0);
    vecs[1]  = mk(3'd0, 32'h10, 32'h0,        1, 0, 1, 1, 32'h00000001, 0, 1);
    vecs[2]  = mk(3'd0, 32'h11, 32'h0,        1, 0, 1, 1, 32'h0000007F, 0, 1);
    vecs[3]  = mk(3'd0, 32'h13, 32'h0,        1, 0, 1, 1, 32'hFFFFFF80, 0, 1);
    vecs[4]  = mk(3'd2, 32'h20, 32'h11223344, 0, 1, 0, 0, 32'h0,        0, 0);
    vecs[5]  = mk(3'd1, 32'h22, 32'h1234BEEF, 0, 1, 0, 0, 32'h0,        0, 0);
    vecs[6]  = mk(3'd5, 32'h22, 32'h0,        1, 0, 1, 1, 32'h0000BEEF, 0, 1);
    vecs[7]  = mk(3'd1, 32'h22, 32'h0,        1, 0, 1, 1, 32'hFFFFBEEF, 0, 1);
    vecs[8]  = mk(3'd2, 32'h20, 32'h0,        1, 0, 1, 1, 32'hBEEF3344, 0, 1);
    vecs[9]  = mk(3'd2, 32'h12, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0,        1, 0);
    vecs[10] = mk(3'd2, 32'h10, 32'h0,        1, 0, 1, 1, 32'h80FF7F01, 0, 1);
    vecs[11] = mk(3'd1, 32'h11, 32'h0,        1, 0, 1, 0, 32'h0,        1, 0);
    vecs[12] = mk(3'd4, 32'h13, 32'h0,        1, 0, 1, 1, 32'h00000080, 0, 1);
    vecs[13] = mk(3'd0, 32'h21, 32'hFFFFFF5A, 0, 1, 0, 0, 32'h0,        0, 0);
    vecs[14] = mk(3'd2, 32'h20, 32'h0,        1, 0, 1, 1, 32'hBEEF5A44, 0, 1);
    vecs[15] = mk(3'd2, 32'h16, 32'h0,        1, 0, 1, 0, 32'h0,        1, 0);
    vecs[16] = mk(3'd7, 32'h11, 32'h0,        1, 0, 1, 0, 32'h0,        0, 1);

    rst = 1'b1; en = 1'b1; clear = 1'b0; result = 64'h0; rd = 5'd0;
    drive(3'd0, 64'h0, 64'h0, 0, 0, 0);
    step();
    step();
    check_zero32("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, 64'(vecs[i].addr), 64'(vecs[i].wd), vecs[i].rd, vecs[i].wr, vecs[i].rw);
      result = 64'(32'hA5000000 + i);
      rd = 5'(i + 1);
      step();
      check($sformatf("vec%0d.misalign", i), 64'(mis32), 64'(vecs[i].exp_mis));
      check($sformatf("vec%0d.reg_write", i), 64'(rw32), 64'(vecs[i].exp_rw));
      check($sformatf("vec%0d.result", i), 64'(r32), 64'(32'hA5000000 + i));
      check($sformatf("vec%0d.rd", i), 64'(rd32), 64'(i + 1));
      if (vecs[i].chk_ld) check($sformatf("vec%0d.load", i), 64'(ld32), 64'(vecs[i].exp_ld));
    end

    // Stall hold: address moves during the stall, data must not.
    drive(3'd2, 64'h10, 64'h0, 1, 0, 1);
    rd = 5'd9;
    step();
    check("stall.first", 64'(ld32), 64'h80FF7F01);
    en = 1'b0;
    drive(3'd0, 64'h40, 64'h0, 1, 0, 1);
    rd = 5'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d.load", k), 64'(ld32), 64'h80FF7F01);
      check($sformatf("stall%0d.rd", k), 64'(rd32), 64'd9);
    end
    en = 1'b1;

    // Flush a load.
    drive(3'd2, 64'h10, 64'h0, 1, 0, 1);
    result = 64'hABCD; rd = 5'd7; clear = 1'b1;
    step();
    clear = 1'b0;
    check_zero32("clear");

    // Reset while stalled.
    step();
    check("prerst.load", 64'(ld32), 64'h80FF7F01);
    en = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_zero32("rst_stall");
    rst = 1'b0; en = 1'b1;

    // XLEN=64 instance.
    result = 64'h0; rd = 5'd1;
    drive(3'd3, 64'h8, 64'h8000000000000001, 0, 1, 0);
    step();
    drive(3'd6, 64'hC, 64'h0, 1, 0, 1);
    step();
    check("x64.lwu", ld64, 64'h0000000080000000);
    check("x64.lwu.mis", 64'(mis64), 64'h0);
    drive(3'd2, 64'hC, 64'h0, 1, 0, 1);
    step();
    check("x64.lw", ld64, 64'hFFFFFFFF80000000);
    drive(3'd3, 64'h8, 64'h0, 1, 0, 1);
    step();
    check("x64.ld", ld64, 64'h8000000000000001);
    drive(3'd3, 64'hC, 64'h0, 1, 0, 1);
    step();
    check("x64.ld.mis", 64'(mis64), 64'h1);
    check("x64.ld.rw", 64'(rw64), 64'h0);

    // Randomized traffic against the byte-array model.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      drive(3'd2, 64'(32'h100 + 4 * w), 64'(d), 0, 1, 0);
      for (int b = 0; b < 4; b++) mbytes[4 * w + b] = d[8 * b +: 8];
      step();
    end
    exp_ld = 32'h0; exp_chk = 1'b0; exp_mis = 1'b0; exp_rw = 1'b0;
    lops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    sops = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0, 3'd3, 3'd7};

    for (int n = 0; n < 400; n++) begin
      logic        is_ld, regw, legal, mis;
      logic [2:0]  o;
      int unsigned a, sz;
      logic [31:0] d;
      en    = ($urandom_range(3) != 0);
      is_ld = $urandom_range(1) == 1;
      o     = is_ld ? lops[$urandom_range(7)] : sops[$urandom_range(7)];
      a     = 32'h100 + $urandom_range(63);
      d     = $urandom;
      regw  = is_ld ? 1'b1 : 1'($urandom_range(1));
      drive(o, 64'(a), 64'(d), is_ld, !is_ld, regw);
      if (en) begin
        legal   = !(o == 3'd3 || o == 3'd6 || o == 3'd7);
        sz      = 1 << o[1:0];
        mis     = legal && ((a % sz) != 0);
        exp_mis = mis;
        exp_rw  = regw && !mis;
        exp_chk = is_ld && legal && !mis;
        if (exp_chk) exp_ld = model_load(o, a);
        if (!is_ld && legal && !mis) begin
          for (int unsigned b = 0; b < sz; b++) mbytes[a - 32'h100 + b] = d[8 * b +: 8];
        end
      end
      step();
      check("rand.misalign", 64'(mis32), 64'(exp_mis));
      check("rand.reg_write", 64'(rw32), 64'(exp_rw));
      if (exp_chk) check("rand.load", 64'(ld32), 64'(exp_ld));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_seg_mem.md
Name: wb_seg_mem

Overview:
- Parametrised write-back segment register with an embedded synchronous data RAM, for the pipelined RISC-V core.
- Sits between the MEM and WB stages and registers the MEM→WB control/result fields.
- Performs the store byte-lane alignment, the load extraction and sign/zero extension, and misalignment detection.
- Holds load data correctly across multi-cycle stalls, which its predecessor could not; supports a synchronous reset.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- DEPTH_LOG2, 12, log2 of RAM depth in XLEN-wide words.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  stage enable; 0 = stall, all stage state held.
- clear  in  1  flush; WB stage becomes a bubble on the next enabled edge.
- addr_m  in  XLEN  byte address from MEM.
- wd_m  in  XLEN  store data, LSB-aligned.
- mem_op_m  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- mem_read_m  in  1  load in MEM.
- mem_write_m  in  1  store in MEM.
- result_m  in  XLEN  ALU result.
- rd_m  in  RD_W  destination register.
- reg_write_m  in  1  register write enable.
- mem_to_reg_m  in  1  select load data in WB.
- result_w  out  XLEN  registered result.
- rd_w  out  RD_W  registered destination.
- reg_write_w  out  1  registered write enable; forced 0 on a misaligned load.
- mem_to_reg_w  out  1  registered select.
- load_data_w  out  XLEN  extracted and extended load data.
- misalign_w  out  1  the WB-stage access was misaligned.

Behaviour:
- Reset:
  - rst has priority over en and clear.
  - At the edge where rst=1, result_w, rd_w, reg_write_w, mem_to_reg_w and misalign_w become 0, and the internal byte offset, mem_op and hold state are cleared.
  - load_data_w reads 0 in the cycle after reset.
  - RAM contents are not reset.
- Stage registers:
  - On an edge with en=1 and clear=0, every *_w register captures its *_m input.
  - The internal byte offset (addr_m[log2(XLEN/8)-1:0]) and mem_op_m are also captured.
  - On an edge with en=1 and clear=1, the outputs capture 0 (a bubble).
  - On an edge with en=0, all stage state is held; clear is ignored.
- Misalignment:
  - An access is misaligned when the address is not a multiple of its access size in bytes (size = 1 << mem_op[1:0]).
  - For a misaligned access, misalign_w=1 and reg_write_w=0 in WB.
- Stores:
  - Byte enable = ((1 << size) - 1) << offset.
  - Write data = wd_m << (8*offset).
  - The RAM is written at the edge only if mem_write_m=1, en=1, clear=0, rst=0 and the access is aligned.
  - A misaligned store writes nothing.
  - An illegal op (011 or 110 when XLEN=32, or 111) writes nothing and is not flagged.
- Loads:
  - The RAM has a synchronous read port addressed by addr_m[DEPTH_LOG2+log2(XLEN/8)-1 : log2(XLEN/8)]; addresses above the depth alias.
  - The word read is shifted right by 8*offset_w, then sign-extended for LB/LH/LW or zero-extended for LBU/LHU/LWU.
  - load_data_w is combinational in the WB cycle, so load latency is one edge.
- Stall hold:
  - The register stall_q is set to ~en at each edge.
  - A hold register captures the extended load data whenever stall_q=0.
  - While stall_q=1, load_data_w comes from the hold register.
  - A stall of any length therefore returns the value of the first WB cycle.
- Clear: in the cycle after a clear edge with en=1, load_data_w=0.
- Read-during-write: a store in MEM and a load in WB are different instructions. The RAM is read-first, and this never forwards.

Optional Feature:
- Macro: WB_SEG_MEM_DEBUG_PORT_EN.
- When defined, the block adds a second true-dual RAM port with these ports:
  - dbg_addr  in  XLEN
  - dbg_wd  in  XLEN
  - dbg_we  in  XLEN/8
  - dbg_rd  out  XLEN
- Debug port behaviour:
  - Synchronous read, byte-write, word-addressed.
  - A simultaneous write from both ports to the same word is undefined; the bench avoids it.
- When the macro is undefined, these ports do not exist and the RAM is single-port.

Test Plan:
- XLEN=32: SW 0x80FF7F01 to 0x10, then LB from 0x10, 0x11 and 0x13 → load_data_w = 0x00000001, 0x0000007F, 0xFFFFFF80.
- SH 0xBEEF to 0x22, then LHU from 0x22 → 0x0000BEEF; LH from 0x22 → 0xFFFFBEEF; the bytes at 0x20 and 0x21 are unchanged.
- LW from 0x10, then en=0 for 3 cycles while addr_m changes to 0x40 → load_data_w stays 0x80FF7F01 throughout the stall.
- SW to 0x12 → no RAM write, misalign_w=1, reg_write_w=0; a subsequent LW from 0x10 still returns 0x80FF7F01.
- A load with clear=1, en=1 → next cycle all outputs are 0. Then assert rst mid-stall (en=0) → next cycle all outputs are 0, and load_data_w=0.
- XLEN=64: SD 0x8000000000000001 to 0x8, then LWU from 0xC → 0x0000000080000000; LW from 0xC → 0xFFFFFFFF80000000.
